// File: rtl/lsu_split.sv
// lsu_split: turns core byte/half/word loads and stores into 32-bit bus beats with byte strobes.
// Define LSU_MISALIGN_SPLIT_EN to service misaligned accesses (two beats when crossing a word).
module lsu_split #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_strb,
  input  logic              mem_req_ready,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_rready
);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t state_q, state_d;

  logic              r_we, r_uns, r_err, r_split;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, rd0_q, rd1_q;

  function automatic logic [2:0] len_of(input logic [1:0] size);
    case (size)
      2'd0:    len_of = 3'd1;
      2'd1:    len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // Classify the incoming request at accept time
  logic in_err, in_split;
`ifdef LSU_MISALIGN_SPLIT_EN
  assign in_err   = (req_size == 2'd3);
  assign in_split = !in_err && ((5'(req_addr[1:0]) + 5'(len_of(req_size))) > 5'd4);
`else
  assign in_err   = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  assign in_split = 1'b0;
`endif

  // Lane placement of the latched access across a two-word window
  logic [1:0]        off;
  logic [2:0]        len;
  logic [7:0]        mask8;
  logic [63:0]       wd64;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] rword, load_res;

  always_comb begin
    off   = r_addr[1:0];
    len   = len_of(r_size);
    mask8 = 8'(((8'd1 << len) - 8'd1) << off);
    wd64  = 64'(r_wdata) << {off, 3'b000};
    base  = {r_addr[ADDR_W-1:2], 2'b00};
    rword = 32'({rd1_q, rd0_q} >> {off, 3'b000});
    case (r_size)
      2'd0:    load_res = r_uns ? {24'd0, rword[7:0]}  : {{24{rword[7]}},  rword[7:0]};
      2'd1:    load_res = r_uns ? {16'd0, rword[15:0]} : {{16{rword[15]}}, rword[15:0]};
      default: load_res = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and Moore outputs; all outputs forced low while rst is high
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    mem_strb   = '0;
    mem_rready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = in_err ? RESP : REQ0;
      end
      REQ0: begin
        mem_read  = !r_we;
        mem_write = r_we;
        mem_addr  = base;
        mem_strb  = mask8[3:0];
        mem_wdata = wd64[31:0];
        if (mem_req_ready) state_d = !r_we ? WAIT0 : (r_split ? REQ1 : RESP);
      end
      WAIT0: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_d = r_split ? REQ1 : RESP;
      end
      REQ1: begin
        mem_read  = !r_we;
        mem_write = r_we;
        mem_addr  = ADDR_W'(base + ADDR_W'(4));
        mem_strb  = mask8[7:4];
        mem_wdata = wd64[63:32];
        if (mem_req_ready) state_d = r_we ? RESP : WAIT1;
      end
      WAIT1: begin
        mem_rready = 1'b1;
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_we || r_err) ? '0 : load_res;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_addr   = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      mem_strb   = '0;
      mem_rready = 1'b0;
    end
  end

  // Request latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_split <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_err   <= in_err;
        r_split <= in_split;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        rd0_q   <= '0;
        rd1_q   <= '0;
      end
      if (state_q == WAIT0 && mem_rvalid) rd0_q <= mem_rdata;
      if (state_q == WAIT1 && mem_rvalid) rd1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split: directed accesses, bus stalls, response backpressure and mid-access reset.
`timescale 1ns/1ps
module tb_lsu_split;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write, mem_req_ready, mem_rvalid, mem_rready;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_strb;

  always #5 clk = ~clk;

  lsu_split #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  beat_t       exp_beats[$];
  resp_t       exp_resps[$];
  logic [31:0] rdq[$];
  beat_t       eb;
  resp_t       er;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, rv_cyc = 0, acc_cyc = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers reads from rdq with zero wait; spurious rvalid whenever not reading
  always @(negedge clk) begin
    if (mem_rready) begin
      if (rdq.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdq.pop_front();
      end else begin
        mem_rvalid = 1'b0;
      end
    end else begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
    end
  end

  // Monitor: compares every presented beat and response against the scoreboard heads
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && !rv_prev) rv_cyc = cyc;
      rv_prev = resp_valid;
      if (mem_read || mem_write) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 64'(1), 64'(0));
        else begin
          eb = exp_beats[0];
          chk("beat_addr", 64'(mem_addr), 64'(eb.addr));
          chk("beat_write", 64'(mem_write), 64'(eb.we));
          chk("beat_read", 64'(mem_read), 64'(!eb.we));
          chk("beat_strb", 64'(mem_strb), 64'(eb.strb));
          if (eb.we) chk("beat_wdata", 64'(mem_wdata), 64'(eb.wdata));
          if (mem_req_ready) void'(exp_beats.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_resps.size() == 0) chk("unexpected_resp", 64'(1), 64'(0));
        else begin
          er = exp_resps[0];
          chk("resp_rdata", 64'(resp_rdata), 64'(er.rdata));
          chk("resp_err", 64'(resp_err), 64'(er.err));
          if (resp_ready) void'(exp_resps.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                      input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.we = we; b.strb = strb; b.wdata = wdata;
    exp_beats.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    resp_t r;
    int n = 0;
    r.rdata = exp_rdata; r.err = exp_err;
    exp_resps.push_back(r);
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = ~addr; req_wdata = ~wdata;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_resps.size() != 0 || exp_beats.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_mem_read"},   64'(mem_read),   64'(0));
    chk({tag, "_mem_write"},  64'(mem_write),  64'(0));
    chk({tag, "_mem_rready"}, 64'(mem_rready), 64'(0));
    chk({tag, "_mem_strb"},   64'(mem_strb),   64'(0));
    chk({tag, "_mem_addr"},   64'(mem_addr),   64'(0));
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'(0));
    chk({tag, "_resp_err"},   64'(resp_err),   64'(0));
  endtask

  initial begin
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = '0; req_wdata = '0;
    resp_ready = 1; mem_req_ready = 1; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 0;
    #1;
    chk("post_reset_req_ready", 64'(req_ready), 64'(1));

    // Aligned word load and its latency
    beat(32'h100, 0, 4'hF, 0); rdq.push_back(32'h11223344);
    issue(0, 2'd2, 0, 32'h100, 0, 32'h11223344, 0); wait_done();
    chk("lw_latency", 64'(rv_cyc - acc_cyc), 64'(2));

    beat(32'h100, 0, 4'h8, 0); rdq.push_back(32'h80123456);
    issue(0, 2'd0, 0, 32'h103, 0, 32'hFFFFFF80, 0); wait_done();
    beat(32'h100, 0, 4'h8, 0); rdq.push_back(32'h80123456);
    issue(0, 2'd0, 1, 32'h103, 0, 32'h00000080, 0); wait_done();
    beat(32'h100, 1, 4'hC, 32'hABCD0000);
    issue(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 0, 0); wait_done();
    beat(32'h100, 0, 4'h3, 0); rdq.push_back(32'h1234F00D);
    issue(0, 2'd1, 0, 32'h100, 0, 32'hFFFFF00D, 0); wait_done();
    beat(32'h100, 0, 4'hC, 0); rdq.push_back(32'h80010000);
    issue(0, 2'd1, 1, 32'h102, 0, 32'h00008001, 0); wait_done();
    beat(32'h100, 1, 4'h2, 32'h0000EE00);
    issue(1, 2'd0, 0, 32'h101, 32'h000000EE, 0, 0); wait_done();
    beat(32'h104, 0, 4'hF, 0); rdq.push_back(32'h87654321);
    issue(0, 2'd2, 1, 32'h104, 0, 32'h87654321, 0); wait_done();
    issue(0, 2'd3, 0, 32'h100, 0, 0, 1); wait_done();

`ifdef LSU_MISALIGN_SPLIT_EN
    beat(32'h0FC, 1, 4'hC, 32'hBBAA0000); beat(32'h100, 1, 4'h3, 32'h0000DDCC);
    issue(1, 2'd2, 0, 32'h0FE, 32'hDDCCBBAA, 0, 0); wait_done();
    beat(32'hFFFFFFFC, 0, 4'hE, 0); beat(32'h0, 0, 4'h1, 0);
    rdq.push_back(32'h332211AB); rdq.push_back(32'hCDEF0044);
    issue(0, 2'd2, 0, 32'hFFFFFFFD, 0, 32'h44332211, 0); wait_done();
    beat(32'h100, 0, 4'h6, 0); rdq.push_back(32'h00ABCD00);
    issue(0, 2'd1, 0, 32'h101, 0, 32'hFFFFABCD, 0); wait_done();
    beat(32'h100, 0, 4'h8, 0); beat(32'h104, 0, 4'h1, 0);
    rdq.push_back(32'h77000000); rdq.push_back(32'h00000088);
    issue(0, 2'd1, 1, 32'h103, 0, 32'h00008877, 0); wait_done();
`else
    issue(1, 2'd2, 0, 32'h0FE, 32'hDDCCBBAA, 0, 1); wait_done();
    issue(0, 2'd2, 0, 32'hFFFFFFFD, 0, 0, 1); wait_done();
    issue(0, 2'd1, 0, 32'h101, 0, 0, 1); wait_done();
    issue(0, 2'd1, 1, 32'h103, 0, 0, 1); wait_done();
`endif

    // Bus stall then response backpressure; monitor checks held values every cycle
    mem_req_ready = 0; resp_ready = 0;
    beat(32'h200, 1, 4'hF, 32'h11111111);
    issue(1, 2'd2, 0, 32'h200, 32'h11111111, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'(0));
    chk("stall_mem_write", 64'(mem_write), 64'(1));
    mem_req_ready = 1;
    for (int i = 0; i < 20 && !resp_valid; i++) begin @(posedge clk); #1; end
    chk("stall_resp_valid", 64'(resp_valid), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("backpressure_resp_valid", 64'(resp_valid), 64'(1));
    resp_ready = 1;
    wait_done();

    // Reset while a load waits for read data (second beat when splitting)
`ifdef LSU_MISALIGN_SPLIT_EN
    beat(32'h1FC, 0, 4'hC, 0); beat(32'h200, 0, 4'h3, 0); rdq.push_back(32'h12345678);
    issue(0, 2'd2, 0, 32'h1FE, 0, 0, 0);
`else
    beat(32'h300, 0, 4'hF, 0);
    issue(0, 2'd2, 0, 32'h300, 0, 0, 0);
`endif
    for (int i = 0; i < 50 && !(mem_rready && exp_beats.size() == 0); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_waiting", 64'(mem_rready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk_quiet("abort_rst");
    @(posedge clk); #1;
    rst = 0;
    exp_resps.delete(); exp_beats.delete(); rdq.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("abort_req_ready", 64'(req_ready), 64'(1));
      chk_quiet("abort_after");
      @(posedge clk); #1;
    end

    beat(32'h100, 0, 4'h8, 0); rdq.push_back(32'h80123456);
    issue(0, 2'd0, 1, 32'h103, 0, 32'h00000080, 0); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
